// File: rtl/mips_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_dbg_pkg
// Description : Shared widths, defaults and dump FSM state encoding for the
//               processor register-dump debug block.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_dbg_pkg;

    localparam int REG_W           = 32;
    localparam int IDX_W           = 5;
    localparam int SETTLE_DEFAULT  = 2;
    localparam int A0_HOLD_DEFAULT = 4;
    localparam int SETTLE_CNT_W    = 4;
    localparam int A0_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2,
        ST_DONE   = 2'd3
    } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/a0_inject.sv
`default_nettype none
// ============================================================================
// Module      : a0_inject
// Description : Latches a value for the processor $a0 input and holds the
//               enable high for A0_HOLD cycles after each load request.
// Revision    : 1.0 - initial release
// ============================================================================
module a0_inject
    import mips_dbg_pkg::*;
#(
    parameter int A0_HOLD = A0_HOLD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [REG_W-1:0] i_value,
    output logic [REG_W-1:0] o_value,
    output logic             o_en
);

    localparam logic [A0_CNT_W-1:0] c_hold_count = A0_CNT_W'(A0_HOLD);

    logic [REG_W-1:0]    r_value;
    logic [A0_CNT_W-1:0] r_hold;

    // A reload during an active hold restarts the full count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value <= '0;
            r_hold  <= '0;
        end else if (i_load) begin
            r_value <= i_value;
            r_hold  <= c_hold_count;
        end else if (r_hold != '0) begin
            r_hold  <= r_hold - A0_CNT_W'(1);
        end
    end

    assign o_value = r_value;
    assign o_en    = (r_hold != '0);

endmodule
`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_ctrl
// Description : Walks a wrapping range of processor registers through the
//               display port and streams them out over a valid/ready link.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int SETTLE  = SETTLE_DEFAULT,
    parameter int A0_HOLD = A0_HOLD_DEFAULT
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [IDX_W-1:0] iFirst,
    input  logic [IDX_W-1:0] iLast,
    output logic [IDX_W-1:0] oRegDispSelect,
    input  logic [REG_W-1:0] iRegDisp,
    output logic [REG_W-1:0] oData,
    output logic [IDX_W-1:0] oIdx,
    output logic             oValid,
    input  logic             iReady,
    output logic             oBusy,
    output logic             oDone,
    input  logic [REG_W-1:0] iA0Value,
    input  logic             iA0Load,
    output logic [REG_W-1:0] oRegA0,
    output logic             oInputA0En
);

    localparam logic [SETTLE_CNT_W-1:0] c_settle_count = SETTLE_CNT_W'(SETTLE);

    dump_state_e             r_state;
    dump_state_e             w_next;
    logic                    w_start;
    logic                    w_capture;
    logic                    w_advance;

    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        r_sel;
    logic [SETTLE_CNT_W-1:0] r_cnt;
    logic [REG_W-1:0]        r_data;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_valid;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over a same-cycle handshake and never produces a done pulse.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iStart && !iAbort) begin
                    w_start = 1'b1;
                    w_next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (iAbort) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    w_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (iAbort) begin
                    w_next = ST_IDLE;
                end else if (r_valid && iReady) begin
                    if (r_idx == r_last) begin
                        w_next = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The select keeps its last value in IDLE; only start/advance move it.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_last  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_last <= iLast;
                r_sel  <= iFirst;
                r_cnt  <= c_settle_count;
            end else if (w_advance) begin
                r_sel  <= r_sel + IDX_W'(1);
                r_cnt  <= c_settle_count;
            end else if ((r_state == ST_SETTLE) && (r_cnt != '0)) begin
                r_cnt  <= r_cnt - SETTLE_CNT_W'(1);
            end

            if (w_capture) begin
                r_data  <= iRegDisp;
                r_idx   <= r_sel;
                r_valid <= 1'b1;
            end else if (w_next != ST_SEND) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign oRegDispSelect = r_sel;
    assign oData          = r_data;
    assign oIdx           = r_idx;
    assign oValid         = r_valid;
    assign oBusy          = (r_state != ST_IDLE);
    assign oDone          = (r_state == ST_DONE);

    a0_inject #(
        .A0_HOLD (A0_HOLD)
    ) u_a0_inject (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_load  (iA0Load),
        .i_value (iA0Value),
        .o_value (oRegA0),
        .o_en    (oInputA0En)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_ctrl
// Description : Scoreboard bench for reg_dump_ctrl: dump words, backpressure,
//               abort, reset and $a0 injection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_ctrl;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_word_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic        iAbort = 1'b0;
    logic [4:0]  iFirst = '0;
    logic [4:0]  iLast = '0;
    logic [4:0]  oRegDispSelect;
    logic [31:0] iRegDisp;
    logic [31:0] oData;
    logic [4:0]  oIdx;
    logic        oValid;
    logic        iReady = 1'b1;
    logic        oBusy;
    logic        oDone;
    logic [31:0] iA0Value = '0;
    logic        iA0Load = 1'b0;
    logic [31:0] oRegA0;
    logic        oInputA0En;

    logic [31:0] r_salt = 32'h0000_0100;
    exp_word_t   sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          n_hs = 0;
    int          n_a0 = 0;
    logic        r_hs_prev = 1'b0;

    // Stand-in for the processor register file display port.
    assign iRegDisp = r_salt + {27'b0, oRegDispSelect};

    always #5 iCLK = ~iCLK;

    reg_dump_ctrl #(
        .SETTLE  (2),
        .A0_HOLD (4)
    ) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iStart         (iStart),
        .iAbort         (iAbort),
        .iFirst         (iFirst),
        .iLast          (iLast),
        .oRegDispSelect (oRegDispSelect),
        .iRegDisp       (iRegDisp),
        .oData          (oData),
        .oIdx           (oIdx),
        .oValid         (oValid),
        .iReady         (iReady),
        .oBusy          (oBusy),
        .oDone          (oDone),
        .iA0Value       (iA0Value),
        .iA0Load        (iA0Load),
        .oRegA0         (oRegA0),
        .oInputA0En     (oInputA0En)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge iCLK) begin
        exp_word_t e;
        if (oDone) n_done++;
        if (oInputA0En) n_a0++;
        if (r_hs_prev) check("valid_drop", {31'b0, oValid}, 32'd0);
        r_hs_prev = 1'b0;
        if (oValid && iReady && !iAbort && !iRST) begin
            n_hs++;
            r_hs_prev = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_word", {27'b0, oIdx}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("word_idx", {27'b0, oIdx}, {27'b0, e.idx});
                check("word_data", oData, e.data);
            end
        end
    end

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        logic [4:0] n;
        exp_word_t  e;
        @(posedge iCLK); #1;
        iStart = 1'b1;
        iFirst = f;
        iLast  = l;
        n = l - f;
        for (int i = 0; i <= int'(n); i++) begin
            e.idx  = f + 5'(i);
            e.data = r_salt + {27'b0, e.idx};
            sb_q.push_back(e);
        end
        @(posedge iCLK); #1;
        iStart = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (oBusy && k < max) begin
            @(posedge iCLK); #1;
            k++;
        end
        check("idle_timeout", {31'b0, oBusy}, 32'd0);
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!oValid && k < max) begin
            @(posedge iCLK); #1;
            k++;
        end
        check("valid_timeout", {31'b0, oValid}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},  {27'b0, oRegDispSelect}, 32'd0);
        check({tag, "_data"}, oData, 32'd0);
        check({tag, "_idx"},  {27'b0, oIdx}, 32'd0);
        check({tag, "_valid"}, {31'b0, oValid}, 32'd0);
        check({tag, "_busy"}, {31'b0, oBusy}, 32'd0);
        check({tag, "_done"}, {31'b0, oDone}, 32'd0);
        check({tag, "_a0"},   oRegA0, 32'd0);
        check({tag, "_a0en"}, {31'b0, oInputA0En}, 32'd0);
    endtask

    initial begin
        int base_done;
        int base_hs;
        int base_a0;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;

        // Basic 3-word dump with first-valid latency.
        base_done = n_done;
        start_dump(5'd3, 5'd5);
        check("busy_settle", {31'b0, oBusy}, 32'd1);
        repeat (2) begin @(posedge iCLK); #1; end
        check("lat_early", {31'b0, oValid}, 32'd0);
        @(posedge iCLK); #1;
        check("lat_first", {31'b0, oValid}, 32'd1);
        wait_idle(100);
        check("done_count_a", n_done - base_done, 32'd1);
        check("sb_empty_a", sb_q.size(), 32'd0);

        // Wrapping range, with a stray start while busy.
        r_salt    = 32'hA5A5_0000;
        base_done = n_done;
        start_dump(5'd30, 5'd1);
        @(posedge iCLK); #1;
        iStart = 1'b1; iFirst = 5'd9; iLast = 5'd9;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        wait_idle(100);
        check("done_count_b", n_done - base_done, 32'd1);
        check("sb_empty_b", sb_q.size(), 32'd0);
        check("sel_hold", {27'b0, oRegDispSelect}, 32'd1);

        // Single word, register 0 passed through untouched.
        r_salt    = 32'hCAFE_0000;
        base_done = n_done;
        start_dump(5'd0, 5'd0);
        wait_idle(50);
        check("done_count_c", n_done - base_done, 32'd1);
        check("sb_empty_c", sb_q.size(), 32'd0);

        // Start together with abort in IDLE is ignored.
        @(posedge iCLK); #1;
        iStart = 1'b1; iAbort = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0; iAbort = 1'b0;
        check("abort_start_idle", {31'b0, oBusy}, 32'd0);

        // Backpressure: word must hold for 5 stalled cycles.
        r_salt    = 32'h1357_0000;
        base_done = n_done;
        iReady    = 1'b0;
        start_dump(5'd7, 5'd8);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'b0, oValid}, 32'd1);
            check("stall_idx", {27'b0, oIdx}, 32'd7);
            check("stall_data", oData, 32'h1357_0007);
            @(posedge iCLK); #1;
        end
        iReady = 1'b1;
        wait_idle(50);
        check("done_count_d", n_done - base_done, 32'd1);
        check("sb_empty_d", sb_q.size(), 32'd0);

        // Abort during the second handshake of a 4-word dump.
        r_salt    = 32'h2468_0000;
        base_done = n_done;
        start_dump(5'd10, 5'd13);
        base_hs = n_hs;
        for (int k = 0; k < 40 && !(oValid && n_hs == base_hs + 1); k++) begin
            @(posedge iCLK); #1;
        end
        check("abort_reach", {31'b0, oValid}, 32'd1);
        iAbort = 1'b1;
        @(posedge iCLK); #1;
        iAbort = 1'b0;
        check("abort_valid", {31'b0, oValid}, 32'd0);
        check("abort_busy", {31'b0, oBusy}, 32'd0);
        check("abort_sb_left", sb_q.size(), 32'd3);
        sb_q.delete();
        repeat (2) begin @(posedge iCLK); #1; end
        check("abort_no_done", n_done - base_done, 32'd0);
        start_dump(5'd2, 5'd2);
        wait_idle(50);
        check("after_abort_done", n_done - base_done, 32'd1);
        check("sb_empty_e", sb_q.size(), 32'd0);

        // $a0 injection with reload two cycles in.
        @(posedge iCLK); #1;
        base_a0  = n_a0;
        iA0Load  = 1'b1; iA0Value = 32'hDEAD_BEEF;
        @(posedge iCLK); #1;
        iA0Load  = 1'b0;
        check("a0_first", oRegA0, 32'hDEAD_BEEF);
        check("a0_en_on", {31'b0, oInputA0En}, 32'd1);
        @(posedge iCLK); #1;
        iA0Load  = 1'b1; iA0Value = 32'h1234_5678;
        @(posedge iCLK); #1;
        iA0Load  = 1'b0;
        check("a0_reload", oRegA0, 32'h1234_5678);
        repeat (8) begin @(posedge iCLK); #1; end
        check("a0_en_off", {31'b0, oInputA0En}, 32'd0);
        check("a0_hold_cycles", n_a0 - base_a0, 32'd6);
        check("a0_keep", oRegA0, 32'h1234_5678);

        // Reset mid-SEND and mid-hold, then a clean dump.
        r_salt = 32'h0BAD_0000;
        iReady = 1'b0;
        start_dump(5'd4, 5'd6);
        wait_valid(20);
        iA0Load = 1'b1; iA0Value = 32'h55AA_55AA;
        @(posedge iCLK); #1;
        iA0Load = 1'b0;
        check("pre_rst_a0en", {31'b0, oInputA0En}, 32'd1);
        #2 iRST = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge iCLK); #1;
        iRST = 1'b0;
        sb_q.delete();
        iReady    = 1'b1;
        base_done = n_done;
        start_dump(5'd20, 5'd21);
        wait_idle(60);
        check("post_rst_done", n_done - base_done, 32'd1);
        check("sb_empty_f", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
